// File: rtl/slow_clock_monitor_pkg.sv
//------------------------------------------------------------------------------
// Module      : slow_clock_monitor_pkg
// Description : Shared definitions for the slow clock monitor: FSM state type
//               and state encodings, plus the default parameter values used
//               by slow_clock_monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package slow_clock_monitor_pkg;

    // Default parameter values for slow_clock_monitor
    localparam int c_DEF_CNT_W      = 8;
    localparam int c_DEF_LOCK_COUNT = 4;
    localparam int c_DEF_TOL        = 1;
    localparam int c_DEF_TIMEOUT    = 64;

    // FSM state type and encodings
    typedef logic [1:0] state_t;

    localparam state_t c_ST_UNLOCKED = 2'd0;
    localparam state_t c_ST_ACQUIRE  = 2'd1;
    localparam state_t c_ST_LOCKED   = 2'd2;
    localparam state_t c_ST_LOST     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//------------------------------------------------------------------------------
// Module      : sync_edge_detect
// Description : Two-flop synchronizer followed by a previous-level register.
//               An edge is flagged while the synchronized level differs from
//               the previous-level register.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               din  - asynchronous level to observe
//               rise - high for one cycle after a low-to-high transition
//               fall - high for one cycle after a high-to-low transition
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;
    assign fall = ~r_sync2 & r_prev;

endmodule

`default_nettype wire

// File: rtl/slow_clock_monitor.sv
//------------------------------------------------------------------------------
// Module      : slow_clock_monitor
// Description : Measures half-period and period of a slow divided clock in
//               system-clock cycles, declares lock after LOCK_COUNT
//               consecutive matching periods, and flags loss when no edge is
//               seen for TIMEOUT cycles.
// Ports       : clk         - system clock (rising edge)
//               rst         - synchronous active-high reset
//               clk_slow_in - slow clock under observation
//               rise_stb    - one-cycle pulse per detected rising edge
//               fall_stb    - one-cycle pulse per detected falling edge
//               half_period - cycles between the last two detected edges
//               period      - sum of the last two half-periods, on rise
//               locked      - high while the FSM is LOCKED
//               lost        - sticky loss flag, cleared on LOCKED entry
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int CNT_W      = c_DEF_CNT_W,
    parameter int LOCK_COUNT = c_DEF_LOCK_COUNT,
    parameter int TOL        = c_DEF_TOL,
    parameter int TIMEOUT    = c_DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_slow_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   c_TOL        = (CNT_W + 1)'(TOL);
    localparam logic [3:0]       c_LOCK_COUNT = 4'(LOCK_COUNT);

    logic w_rise;
    logic w_fall;
    logic w_edge;

    sync_edge_detect u_sync_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .din  (clk_slow_in),
        .rise (w_rise),
        .fall (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    logic [CNT_W-1:0] r_hp_cnt;
    logic [CNT_W-1:0] r_half_period;
    logic [CNT_W-1:0] r_period;
    logic [3:0]       r_match_cnt;
    logic [1:0]       r_rise_cnt;    // rises seen since ACQUIRE entry, saturates at 2
    state_t           r_state;
    logic             r_lost;
    logic             r_rise_stb;
    logic             r_fall_stb;

    logic [CNT_W-1:0] w_hp_inc;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_new_period;
    logic [CNT_W:0]   w_diff;
    logic             w_match;
    logic             w_timeout;

    always_comb begin
        // Saturating increment doubles as the new half-period on an edge
        w_hp_inc     = (r_hp_cnt == c_CNT_MAX) ? c_CNT_MAX : r_hp_cnt + 1'b1;
        w_sum        = {1'b0, w_hp_inc} + {1'b0, r_half_period};
        w_new_period = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];
        if (w_new_period >= r_period) begin
            w_diff = {1'b0, w_new_period} - {1'b0, r_period};
        end else begin
            w_diff = {1'b0, r_period} - {1'b0, w_new_period};
        end
        w_match   = (w_diff <= c_TOL);
        // An edge in the timeout cycle wins, so the timeout is masked by it
        w_timeout = !w_edge && (r_hp_cnt == c_TIMEOUT_M1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp_cnt      <= '0;
            r_half_period <= '0;
            r_period      <= '0;
            r_match_cnt   <= '0;
            r_rise_cnt    <= '0;
            r_state       <= c_ST_UNLOCKED;
            r_lost        <= 1'b0;
            r_rise_stb    <= 1'b0;
            r_fall_stb    <= 1'b0;
        end else begin
            r_rise_stb <= w_rise;
            r_fall_stb <= w_fall;
            r_hp_cnt   <= w_edge ? '0 : w_hp_inc;

            if (w_edge) begin
                r_half_period <= w_hp_inc;
            end
            if (w_rise) begin
                r_period <= w_new_period;
            end

            case (r_state)
                c_ST_UNLOCKED, c_ST_LOST: begin
                    if (w_edge) begin
                        r_state     <= c_ST_ACQUIRE;
                        r_match_cnt <= '0;
                        // An entry rise counts as the first load-only rise
                        r_rise_cnt  <= w_rise ? 2'd1 : 2'd0;
                    end
                end
                c_ST_ACQUIRE: begin
                    if (w_rise) begin
                        if (r_rise_cnt != 2'd2) begin
                            r_rise_cnt <= r_rise_cnt + 2'd1;
                        end else if (w_match) begin
                            if (r_match_cnt + 4'd1 == c_LOCK_COUNT) begin
                                r_state     <= c_ST_LOCKED;
                                r_lost      <= 1'b0;
                                r_match_cnt <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 4'd1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state <= c_ST_LOST;
                        r_lost  <= 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_rise && !w_match) begin
                        r_state     <= c_ST_ACQUIRE;
                        r_match_cnt <= '0;
                        r_rise_cnt  <= 2'd1;
                    end else if (w_timeout) begin
                        r_state <= c_ST_LOST;
                        r_lost  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_UNLOCKED;
                end
            endcase
        end
    end

    assign rise_stb    = r_rise_stb;
    assign fall_stb    = r_fall_stb;
    assign half_period = r_half_period;
    assign period      = r_period;
    assign locked      = (r_state == c_ST_LOCKED);
    assign lost        = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_slow_clock_monitor.sv
//------------------------------------------------------------------------------
// Module      : tb_slow_clock_monitor
// Description : Directed self-checking bench for slow_clock_monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_slow_clock_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_slow_in;
    logic             rise_stb;
    logic             fall_stb;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             lost;

    int n_checks   = 0;
    int n_pass     = 0;
    int rise_count = 0;
    int fall_count = 0;

    slow_clock_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (4),
        .TOL        (1),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_slow_in (clk_slow_in),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .half_period (half_period),
        .period      (period),
        .locked      (locked),
        .lost        (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally strobes seen there
    task automatic tick();
        @(negedge clk);
        if (rise_stb) rise_count++;
        if (fall_stb) fall_count++;
    endtask

    // Drive a new level, then hold it for wait_n cycles
    task automatic half_step(input logic lvl, input int wait_n);
        clk_slow_in = lvl;
        repeat (wait_n) tick();
    endtask

    initial begin
        int base_r;
        int base_f;
        int rise_t;
        int fall_t;

        rst         = 1'b1;
        clk_slow_in = 1'b0;
        repeat (3) tick();
        check("rst_rise_stb", rise_stb, 0);
        check("rst_fall_stb", fall_stb, 0);
        check("rst_half_period", half_period, 0);
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);

        // Constant low after reset: no strobes
        rst = 1'b0;
        base_r = rise_count;
        base_f = fall_count;
        repeat (10) tick();
        check("low_no_rise", rise_count - base_r, 0);
        check("low_no_fall", fall_count - base_f, 0);

        // Toggle every 3 cycles: lock on the 6th rise
        for (int r = 1; r <= 6; r++) begin
            if (r > 1) half_step(1'b0, 3);
            half_step(1'b1, 3);
            if (r == 1) check("first_rise_stb", rise_stb, 1);
            if (r == 5) check("lock_not_yet", locked, 0);
        end
        check("lock_locked", locked, 1);
        check("lock_half_period", half_period, 3);
        check("lock_period", period, 6);
        check("lock_lost", lost, 0);

        // One period of 9 drops lock
        half_step(1'b0, 6);
        half_step(1'b1, 3);
        check("dev9_period", period, 9);
        check("dev9_locked", locked, 0);

        // Relock: one load-only rise then four matches
        for (int i = 1; i <= 5; i++) begin
            half_step(1'b0, 3);
            half_step(1'b1, 3);
            if (i == 4) check("relock_not_yet", locked, 0);
        end
        check("relock_locked", locked, 1);

        // Period 7 is within tolerance
        half_step(1'b0, 4);
        half_step(1'b1, 3);
        check("dev7_period", period, 7);
        check("dev7_locked", locked, 1);
        half_step(1'b0, 3);
        half_step(1'b1, 3);
        check("back6_period", period, 6);
        check("back6_locked", locked, 1);

        // Hold low: hp_cnt reaches 63 at the 63rd tick, LOST one cycle later
        half_step(1'b0, 3);
        check("hold_fall_stb", fall_stb, 1);
        repeat (63) tick();
        check("pre_timeout_lost", lost, 0);
        check("pre_timeout_locked", locked, 1);
        tick();
        check("timeout_lost", lost, 1);
        check("timeout_locked", locked, 0);

        // Restart toggling: relock, lost held until LOCKED
        for (int r = 1; r <= 6; r++) begin
            if (r > 1) half_step(1'b0, 3);
            half_step(1'b1, 3);
            if (r == 5) begin
                check("reacq_locked", locked, 0);
                check("reacq_lost", lost, 1);
            end
        end
        check("relock2_locked", locked, 1);
        check("relock2_lost", lost, 0);

        // Fall edge lands exactly when hp_cnt = 63: no LOST
        repeat (61) tick();
        half_step(1'b0, 3);
        check("edge_tmo_fall_stb", fall_stb, 1);
        check("edge_tmo_half", half_period, 64);
        check("edge_tmo_lost", lost, 0);
        check("edge_tmo_locked", locked, 1);
        half_step(1'b1, 3);
        check("long_period", period, 67);
        check("long_locked", locked, 0);
        check("long_lost", lost, 0);

        // Relock, then reset with the input high
        for (int i = 1; i <= 6; i++) begin
            half_step(1'b0, 3);
            half_step(1'b1, 3);
        end
        check("pre_rst_locked", locked, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_rise_stb", rise_stb, 0);
        check("mid_rst_fall_stb", fall_stb, 0);
        check("mid_rst_half", half_period, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_lost", lost, 0);
        tick();
        rst = 1'b0;
        base_r = rise_count;
        base_f = fall_count;
        repeat (10) tick();
        check("post_rst_rises", rise_count - base_r, 1);
        check("post_rst_falls", fall_count - base_f, 0);

        // Single one-cycle pulse on a quiet input
        rst         = 1'b1;
        clk_slow_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        base_r      = rise_count;
        base_f      = fall_count;
        rise_t      = -1;
        fall_t      = -1;
        clk_slow_in = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) clk_slow_in = 1'b0;
            if (rise_stb) rise_t = t;
            if (fall_stb) fall_t = t;
        end
        check("pulse_rise_latency", rise_t, 3);
        check("pulse_fall_latency", fall_t, 4);
        check("pulse_rises", rise_count - base_r, 1);
        check("pulse_falls", fall_count - base_f, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slow_clock_monitor.md
SLOW_CLOCK_MONITOR -- requirements
Module: slow_clock_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and timeout counters; the valid range is 4..16.
REQ-002 Parameter LOCK_COUNT, default 4: number of consecutive matching periods required for lock; the valid range is 1..15.
REQ-003 Parameter TOL, default 1: maximum allowed |period - previous period|, in clk cycles, for two periods to match.
REQ-004 Parameter TIMEOUT, default 64: number of clk cycles without an edge that declares loss; SHALL satisfy 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clk_slow_in  input  1  divided clock under observation; asynchronous to clk in timing, though generated from it.
REQ-008 rise_stb  output  1  one-cycle pulse per detected rising edge of clk_slow_in.
REQ-009 fall_stb  output  1  one-cycle pulse per detected falling edge of clk_slow_in.
REQ-010 half_period  output  CNT_W  clk cycles between the last two detected edges, of either polarity.
REQ-011 period  output  CNT_W  sum of the last two half-periods, captured on rise_stb.
REQ-012 locked  output  1  high only in the LOCKED state.
REQ-013 lost  output  1  sticky loss flag.

Function
REQ-014 clk_slow_in SHALL pass through a 2-flop synchronizer, then a 1-flop previous-level register; an edge is detected when the synchronized level differs from the previous-level register.
REQ-015 Strobe latency: when a clk edge first samples a new input level, the corresponding strobe SHALL be high during the clock cycle following the third clk edge counted from that sampling edge; each strobe is exactly one cycle wide.
REQ-016 hp_cnt SHALL increment every cycle, saturating at 2^CNT_W-1, and clear to 0 in each edge cycle.
REQ-017 In each edge cycle, half_period SHALL load hp_cnt+1, saturating at 2^CNT_W-1.
REQ-018 In each rise cycle, period SHALL load new half_period + stored half_period, saturating at 2^CNT_W-1.
REQ-019 Example: input toggling every 3 clk cycles gives half_period=3 and period=6.
REQ-020 The FSM SHALL have four states: UNLOCKED, ACQUIRE, LOCKED, LOST.
REQ-021 UNLOCKED: any detected edge SHALL move the FSM to ACQUIRE with match_cnt=0; no timeout applies in UNLOCKED.
REQ-022 ACQUIRE: the first and second rise after entry SHALL only load period, with no comparison.
REQ-023 ACQUIRE: each later rise SHALL compare the new period with the previous period; if within TOL, match_cnt increments, otherwise match_cnt clears.
REQ-024 ACQUIRE: when match_cnt reaches LOCK_COUNT, the FSM SHALL move to LOCKED and clear lost.
REQ-025 LOCKED: any rise whose period deviates by more than TOL SHALL return the FSM to ACQUIRE with match_cnt=0, and locked SHALL deassert the next cycle.
REQ-026 In ACQUIRE or LOCKED, when hp_cnt reaches TIMEOUT-1 with no edge in that cycle, the FSM SHALL move to LOST and set lost the next cycle.
REQ-027 An edge and a timeout in the same cycle SHALL be resolved in favour of the edge; no LOST transition occurs.
REQ-028 LOST: the next detected edge SHALL move the FSM to ACQUIRE with match_cnt=0; lost SHALL remain high until LOCKED is re-entered or rst.
REQ-029 Outputs SHALL not change except on edge, timeout, or rst events.

Reset
REQ-030 On rst, synchronizer flops, the previous-level register, hp_cnt, match_cnt, half_period, period, rise_stb, fall_stb, locked and lost SHALL all be 0, and the FSM SHALL be in UNLOCKED.
REQ-031 rst asserted mid-operation SHALL take priority over all events in the same cycle.
REQ-032 After rst deasserts, no strobe SHALL be produced for a constant-low input.
REQ-033 After rst deasserts, an input already high SHALL produce one rise_stb.

Structure
REQ-034 A package slow_clock_monitor_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-035 The synchronizer and edge detector SHALL be a sub-module, sync_edge_detect, with outputs rise and fall.
REQ-036 The counters and FSM SHALL stay in slow_clock_monitor.

Verification
REQ-037 Input toggling every 3 clk cycles from reset -> half_period=3, period=6, locked asserted after the (LOCK_COUNT+2)-th rise_stb, lost=0.
REQ-038 Locked input held low for 64 cycles -> locked=0, lost=1 one cycle after hp_cnt=63; restarting toggles -> relock, lost cleared on LOCKED entry.
REQ-039 While locked at period 6, one period of 9 -> FSM to ACQUIRE, locked=0; period of 7 with TOL=1 -> lock retained.
REQ-040 Edge arriving in the same cycle hp_cnt=TIMEOUT-1 -> no LOST, lost stays 0.
REQ-041 rst pulsed while LOCKED with the input high -> all outputs 0 during reset; exactly one rise_stb after release.
REQ-042 Single input pulse 1 clk wide after reset -> exactly one rise_stb and one fall_stb, one cycle apart.
